// File: rtl/lc3b_types.sv
// Shared LC-3b datapath types, plus the state and client encodings used by
// the cache-to-physical-memory arbiter.
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_line;

  localparam int LC3B_LINE_OFFSET_BITS = 4;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_GRANT_I,
    ARB_GRANT_D
  } arb_state_t;

  typedef enum logic {
    CLIENT_I,
    CLIENT_D
  } arb_client_t;

endpackage

// File: rtl/cache_arbiter.sv
// Serialises I-cache and D-cache line transactions onto the single physical
// memory port, one in flight at a time, and steers the completion back.
module cache_arbiter
  import lc3b_types::*;
#(
  parameter int ADDR_BITS       = 16,
  parameter int LINE_BITS       = 128,
  parameter int OFFSET_BITS     = LC3B_LINE_OFFSET_BITS,
  parameter int DCACHE_PRIORITY = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,

  input  logic                 i_mem_read,
  input  logic                 i_mem_write,
  input  logic [ADDR_BITS-1:0] i_mem_address,
  input  logic [LINE_BITS-1:0] i_mem_wdata,
  output logic [LINE_BITS-1:0] i_mem_rdata,
  output logic                 i_mem_resp,

  input  logic                 d_mem_read,
  input  logic                 d_mem_write,
  input  logic [ADDR_BITS-1:0] d_mem_address,
  input  logic [LINE_BITS-1:0] d_mem_wdata,
  output logic [LINE_BITS-1:0] d_mem_rdata,
  output logic                 d_mem_resp,

  output logic                 pmem_read,
  output logic                 pmem_write,
  output logic [ADDR_BITS-1:0] pmem_address,
  output logic [LINE_BITS-1:0] pmem_wdata,
  input  logic [LINE_BITS-1:0] pmem_rdata,
  input  logic                 pmem_resp
);

  localparam logic [ADDR_BITS-1:0] ALIGN_MASK = {ADDR_BITS{1'b1}} << OFFSET_BITS;

  arb_state_t            r_state;
  arb_client_t           r_last_grant;
  logic                  r_pmem_read;
  logic                  r_pmem_write;
  logic [ADDR_BITS-1:0]  r_pmem_address;
  logic [LINE_BITS-1:0]  r_pmem_wdata;

  logic                  w_i_req;
  logic                  w_d_req;
  logic                  w_grant_d;

  // A tie goes to D under fixed priority, otherwise to whoever was not served last.
  function automatic logic pick_d(input logic req_i, input logic req_d,
                                  input arb_client_t last);
    if (req_i && req_d) begin
      return (DCACHE_PRIORITY != 0) ? 1'b1 : (last == CLIENT_I);
    end
    return req_d;
  endfunction

  assign w_i_req   = i_mem_read | i_mem_write;
  assign w_d_req   = d_mem_read | d_mem_write;
  assign w_grant_d = pick_d(w_i_req, w_d_req, r_last_grant);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= ARB_IDLE;
      r_last_grant   <= CLIENT_D;
      r_pmem_read    <= 1'b0;
      r_pmem_write   <= 1'b0;
      r_pmem_address <= '0;
      r_pmem_wdata   <= '0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_i_req || w_d_req) begin
            // Write wins when a client raises both strobes.
            if (w_grant_d) begin
              r_state        <= ARB_GRANT_D;
              r_last_grant   <= CLIENT_D;
              r_pmem_read    <= ~d_mem_write;
              r_pmem_write   <= d_mem_write;
              r_pmem_address <= d_mem_address & ALIGN_MASK;
              r_pmem_wdata   <= d_mem_wdata;
            end else begin
              r_state        <= ARB_GRANT_I;
              r_last_grant   <= CLIENT_I;
              r_pmem_read    <= ~i_mem_write;
              r_pmem_write   <= i_mem_write;
              r_pmem_address <= i_mem_address & ALIGN_MASK;
              r_pmem_wdata   <= i_mem_wdata;
            end
          end
        end
        ARB_GRANT_I, ARB_GRANT_D: begin
          if (pmem_resp) begin
            r_state      <= ARB_IDLE;
            r_pmem_read  <= 1'b0;
            r_pmem_write <= 1'b0;
          end
        end
        default: begin
          r_state      <= ARB_IDLE;
          r_pmem_read  <= 1'b0;
          r_pmem_write <= 1'b0;
        end
      endcase
    end
  end

  assign pmem_read    = r_pmem_read;
  assign pmem_write   = r_pmem_write;
  assign pmem_address = r_pmem_address;
  assign pmem_wdata   = r_pmem_wdata;

  // A transaction being abandoned by reset must not complete to its client.
  assign i_mem_resp  = rst_n & pmem_resp & (r_state == ARB_GRANT_I);
  assign d_mem_resp  = rst_n & pmem_resp & (r_state == ARB_GRANT_D);
  assign i_mem_rdata = pmem_rdata;
  assign d_mem_rdata = pmem_rdata;

endmodule

// File: tb/tb_cache_arbiter.sv
// Bench for cache_arbiter: one round-robin and one D-priority instance share
// stimulus and are compared every cycle against a transaction-level model.
module tb_cache_arbiter;
  import lc3b_types::*;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [127:0] wd;
    int          dropAfter;
  } req_t;

  localparam logic [127:0] LINE_T1 = 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF;
  localparam logic [127:0] PAT_A   = 128'hA5A5_5A5A_0F0F_F0F0_1234_5678_9ABC_DEF0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cRd [2] = '{1'b0, 1'b0};
  logic cWr [2] = '{1'b0, 1'b0};
  logic [15:0]  cAddr [2] = '{16'h0, 16'h0};
  logic [127:0] cWd   [2] = '{128'h0, 128'h0};
  logic [127:0] pmRdata = '0;
  logic pmResp = 1'b0;

  logic         iRespO [2];
  logic         dRespO [2];
  logic         pRdO   [2];
  logic         pWrO   [2];
  logic [15:0]  pAddrO [2];
  logic [127:0] pWdO   [2];
  logic [127:0] iRdO   [2];
  logic [127:0] dRdO   [2];

  int errors = 0;
  int checks = 0;

  // Reference model: who owns the memory port and what it was asked to do.
  int           mOwner [2] = '{0, 0};
  bit           mWrite [2] = '{1'b0, 1'b0};
  bit           mLastD [2] = '{1'b1, 1'b1};
  logic [15:0]  mAddr  [2] = '{16'h0, 16'h0};
  logic [127:0] mWd    [2] = '{128'h0, 128'h0};
  int grantLog0[$];
  int grantLog1[$];
  int pick;

  req_t clientQ [2][$];
  bit   cBusy [2] = '{1'b0, 1'b0};
  int   cAge  [2] = '{0, 0};
  int   cDrop [2] = '{0, 0};
  logic respSeen [2] = '{1'b0, 1'b0};
  int   respCount [2] = '{0, 0};
  logic memActive = 1'b0;
  bit   memOn = 1'b0;
  bit   memRandom = 1'b0;
  bit   spurOn = 1'b0;
  bit   autoOn = 1'b0;
  int   memDelay = 0;
  int   waitCnt = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : gDut
    cache_arbiter #(
      .ADDR_BITS(16), .LINE_BITS(128), .OFFSET_BITS(4), .DCACHE_PRIORITY(g)
    ) dut (
      .clk(clk), .rst_n(rst_n),
      .i_mem_read(cRd[0]), .i_mem_write(cWr[0]), .i_mem_address(cAddr[0]),
      .i_mem_wdata(cWd[0]), .i_mem_rdata(iRdO[g]), .i_mem_resp(iRespO[g]),
      .d_mem_read(cRd[1]), .d_mem_write(cWr[1]), .d_mem_address(cAddr[1]),
      .d_mem_wdata(cWd[1]), .d_mem_rdata(dRdO[g]), .d_mem_resp(dRespO[g]),
      .pmem_read(pRdO[g]), .pmem_write(pWrO[g]), .pmem_address(pAddrO[g]),
      .pmem_wdata(pWdO[g]), .pmem_rdata(pmRdata), .pmem_resp(pmResp)
    );
  end

  task automatic checkOutput(input string name, input int k,
                             input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s dut%0d actual=%h expected=%h t=%0t", name, k, act, exp, $time);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Model advances on the same edge the DUT does, from the same inputs.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        mOwner[k] = 0;
        mLastD[k] = 1'b1;
        mWrite[k] = 1'b0;
        mAddr[k]  = 16'h0;
        mWd[k]    = '0;
      end else if (mOwner[k] == 0) begin
        pick = 0;
        if ((cRd[0] | cWr[0]) && (cRd[1] | cWr[1])) pick = (k == 1 || !mLastD[k]) ? 2 : 1;
        else if (cRd[0] | cWr[0]) pick = 1;
        else if (cRd[1] | cWr[1]) pick = 2;
        if (pick != 0) begin
          mOwner[k] = pick;
          mLastD[k] = (pick == 2);
          mWrite[k] = cWr[pick-1];
          mAddr[k]  = cAddr[pick-1] & 16'hFFF0;
          mWd[k]    = cWd[pick-1];
          if (k == 0) grantLog0.push_back(pick);
          else grantLog1.push_back(pick);
        end
      end else if (pmResp) begin
        mOwner[k] = 0;
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      checkOutput("pmem_read", k, pRdO[k], (mOwner[k] != 0) && !mWrite[k]);
      checkOutput("pmem_write", k, pWrO[k], (mOwner[k] != 0) && mWrite[k]);
      checkOutput("pmem_address", k, pAddrO[k], mAddr[k]);
      checkOutput("pmem_wdata", k, pWdO[k], mWd[k]);
      checkOutput("i_mem_resp", k, iRespO[k], rst_n && pmResp && mOwner[k] == 1);
      checkOutput("d_mem_resp", k, dRespO[k], rst_n && pmResp && mOwner[k] == 2);
      checkOutput("i_mem_rdata", k, iRdO[k], pmRdata);
      checkOutput("d_mem_rdata", k, dRdO[k], pmRdata);
    end
    respSeen[0] = iRespO[0];
    respSeen[1] = dRespO[0];
    if (iRespO[0]) respCount[0]++;
    if (dRespO[0]) respCount[1]++;
    memActive = pRdO[0] | pWrO[0];
  end

  // One cycle of stimulus: memory responder, then each client's driver.
  task automatic step();
    req_t r;
    @(posedge clk);
    #1;
    if (memOn) begin
      pmRdata = rand128();
      if (pmResp) pmResp = 1'b0;
      else if (memActive) begin
        if (waitCnt == 0) begin
          pmResp  = 1'b1;
          waitCnt = memRandom ? int'($urandom_range(0, 3)) : memDelay;
        end else waitCnt--;
      end else if (spurOn && $urandom_range(0, 7) == 0) pmResp = 1'b1;
    end
    if (autoOn) begin
      for (int c = 0; c < 2; c++) begin
        if (cBusy[c] && respSeen[c]) cBusy[c] = 1'b0;
        if (cBusy[c]) begin
          cAge[c]++;
          if (cDrop[c] > 0 && cAge[c] >= cDrop[c] && mOwner[0] == c + 1) begin
            cRd[c] = 1'b0;
            cWr[c] = 1'b0;
          end
        end else if (clientQ[c].size() > 0) begin
          r = clientQ[c].pop_front();
          cRd[c] = r.rd;   cWr[c] = r.wr;
          cAddr[c] = r.addr; cWd[c] = r.wd;
          cDrop[c] = r.dropAfter;
          cAge[c] = 0;
          cBusy[c] = 1'b1;
        end else begin
          cRd[c] = 1'b0;
          cWr[c] = 1'b0;
        end
      end
    end
  endtask

  task automatic applyStimulus(input int c, input logic rd, input logic wr,
                               input logic [15:0] addr, input logic [127:0] wd,
                               input int dropAfter);
    req_t r;
    r.rd = rd; r.wr = wr; r.addr = addr; r.wd = wd; r.dropAfter = dropAfter;
    clientQ[c].push_back(r);
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    pmResp = 1'b0;
    for (int c = 0; c < 2; c++) begin
      clientQ[c].delete();
      cBusy[c] = 1'b0;
      cRd[c] = 1'b0;
      cWr[c] = 1'b0;
    end
    step();
    step();
    rst_n = 1'b1;
    pmResp = 1'b0;
    waitCnt = memDelay;
    grantLog0.delete();
    grantLog1.delete();
  endtask

  task automatic waitDone(input int limit);
    bit done = 1'b0;
    for (int i = 0; i < limit && !done; i++) begin
      done = clientQ[0].size() == 0 && clientQ[1].size() == 0 && !cBusy[0] && !cBusy[1];
      if (!done) step();
    end
    checkOutput("drain_within_budget", 0, done, 1'b1);
  endtask

  function automatic int logCode(input int k);
    int code = 0;
    if (k == 0) foreach (grantLog0[i]) code = code * 10 + grantLog0[i];
    else foreach (grantLog1[i]) code = code * 10 + grantLog1[i];
    return code;
  endfunction

  function automatic int countGrants1(input int who);
    int n = 0;
    foreach (grantLog1[i]) if (grantLog1[i] == who) n++;
    return n;
  endfunction

  initial begin
    int base;
    int kind;
    int lastG;
    doReset();
    @(negedge clk);
    checkOutput("reset_pmem_read", 0, pRdO[0], 0);
    checkOutput("reset_pmem_write", 0, pWrO[0], 0);
    checkOutput("reset_pmem_address", 0, pAddrO[0], 0);
    checkOutput("reset_pmem_wdata", 0, pWdO[0], 0);
    checkOutput("reset_d_resp", 1, dRespO[1], 0);

    // Single I read with zero memory wait.
    step(); cRd[0] = 1'b1; cAddr[0] = 16'h1234;
    @(negedge clk); checkOutput("t1_request_cycle", 0, pRdO[0], 0);
    step();
    @(negedge clk);
    checkOutput("t1_pmem_read", 0, pRdO[0], 1);
    checkOutput("t1_aligned_addr", 0, pAddrO[0], 16'h1230);
    step(); pmResp = 1'b1; pmRdata = LINE_T1;
    @(negedge clk);
    checkOutput("t1_i_resp", 0, iRespO[0], 1);
    checkOutput("t1_i_rdata", 0, iRdO[0], LINE_T1);
    checkOutput("t1_d_resp_quiet", 0, dRespO[0], 0);
    step(); cRd[0] = 1'b0; pmResp = 1'b0;
    @(negedge clk); checkOutput("t1_back_to_idle", 0, pRdO[0], 0);

    // Simultaneous requests, round-robin, twice.
    memOn = 1'b1; memRandom = 1'b0; spurOn = 1'b0; memDelay = 0; autoOn = 1'b1;
    doReset();
    applyStimulus(0, 1, 0, 16'h2000, rand128(), 0);
    applyStimulus(1, 1, 0, 16'h3000, rand128(), 0);
    waitDone(200);
    applyStimulus(0, 1, 0, 16'h2010, rand128(), 0);
    applyStimulus(1, 1, 0, 16'h3010, rand128(), 0);
    waitDone(200);
    checkOutput("t2_rr_order", 0, logCode(0), 1212);

    // D writeback then allocate, with an I read arriving one cycle later.
    doReset();
    applyStimulus(1, 0, 1, 16'h4010, PAT_A, 0);
    applyStimulus(1, 1, 0, 16'h8020, rand128(), 0);
    step();
    applyStimulus(0, 1, 0, 16'h0100, rand128(), 0);
    step();
    @(negedge clk);
    checkOutput("t3_write_strobe", 0, pWrO[0], 1);
    checkOutput("t3_write_data", 0, pWdO[0], PAT_A);
    checkOutput("t3_write_addr", 0, pAddrO[0], 16'h4010);
    waitDone(200);
    checkOutput("t3_order", 0, logCode(0), 212);

    // Both clients held: the priority instance serves only D until D lets go.
    autoOn = 1'b0;
    doReset();
    cRd[0] = 1'b1; cAddr[0] = 16'h0A00;
    cRd[1] = 1'b1; cAddr[1] = 16'h0B00;
    repeat (12) step();
    checkOutput("t4_prio_no_i_grant", 1, countGrants1(1), 0);
    checkOutput("t4_prio_d_served", 1, grantLog1.size() >= 3, 1);
    cRd[1] = 1'b0;
    repeat (8) step();
    lastG = (grantLog1.size() > 0) ? grantLog1[grantLog1.size()-1] : 0;
    checkOutput("t4_prio_i_after_drop", 1, lastG, 1);
    cRd[0] = 1'b0;
    repeat (4) step();

    // Reset during GRANT_D, then a stray pmem_resp in IDLE.
    memOn = 1'b0;
    doReset();
    step(); cRd[1] = 1'b1; cAddr[1] = 16'h5000;
    step();
    @(negedge clk); checkOutput("t5_granted", 0, pRdO[0], 1);
    step(); rst_n = 1'b0; pmResp = 1'b1;
    @(negedge clk); checkOutput("t5_no_resp_in_reset", 0, dRespO[0], 0);
    step(); rst_n = 1'b1; cRd[1] = 1'b0; pmResp = 1'b1;
    @(negedge clk);
    checkOutput("t5_pmem_dropped", 0, pRdO[0], 0);
    checkOutput("t5_late_resp_d", 0, dRespO[0], 0);
    checkOutput("t5_late_resp_i", 0, iRespO[0], 0);
    step(); pmResp = 1'b0;

    // D drops its request right after the grant; it still completes.
    memOn = 1'b1; memDelay = 3; autoOn = 1'b1;
    doReset();
    base = respCount[1];
    applyStimulus(1, 1, 0, 16'h6000, rand128(), 1);
    waitDone(100);
    checkOutput("t6_drop_completes", 1, respCount[1] - base, 1);

    // Randomised traffic with variable memory latency and stray responses.
    memRandom = 1'b1; spurOn = 1'b1;
    doReset();
    base = respCount[0] + respCount[1];
    for (int n = 0; n < 80; n++) begin
      kind = $urandom_range(0, 2);
      applyStimulus($urandom_range(0, 1), kind != 1, kind != 0,
                    16'($urandom_range(0, 65535)), rand128(),
                    ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
    end
    waitDone(4000);
    checkOutput("rand_all_served", 0, respCount[0] + respCount[1] - base, 80);

    autoOn = 1'b0; memOn = 1'b0; pmResp = 1'b0;
    repeat (3) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog simulation did not finish actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/cache_arbiter.md
Name: cache_arbiter

Overview:
- Sits directly downstream of the instruction-cache and data-cache controllers.
- Consumes their arb_mem_read / arb_mem_write line requests and serialises them onto the single physical-memory port.
- Routes pmem_resp back to the granted cache.
- One line transaction is outstanding at a time; ties are broken round-robin unless fixed data-cache priority is selected.

Parameters:
- ADDR_BITS, 16, byte-address width (lc3b_word).
- LINE_BITS, 128, cache line width in bits.
- OFFSET_BITS, 4, line-offset bits forced to zero on pmem_address.
- DCACHE_PRIORITY, 0, 0 = round-robin tie-break; 1 = D-cache always wins ties.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- i_mem_read  in  1  I-cache line read request (level, held until i_mem_resp)
- i_mem_write  in  1  I-cache line write request (level, held until i_mem_resp)
- i_mem_address  in  ADDR_BITS  I-cache line address
- i_mem_wdata  in  LINE_BITS  I-cache writeback line
- i_mem_rdata  out  LINE_BITS  fill line to I-cache
- i_mem_resp  out  1  transaction-complete pulse to I-cache
- d_mem_read  in  1  D-cache line read request
- d_mem_write  in  1  D-cache line write request
- d_mem_address  in  ADDR_BITS  D-cache line address
- d_mem_wdata  in  LINE_BITS  D-cache writeback line
- d_mem_rdata  out  LINE_BITS  fill line to D-cache
- d_mem_resp  out  1  transaction-complete pulse to D-cache
- pmem_read  out  1  physical memory read
- pmem_write  out  1  physical memory write
- pmem_address  out  ADDR_BITS  line-aligned address
- pmem_wdata  out  LINE_BITS  write line
- pmem_rdata  in  LINE_BITS  read line
- pmem_resp  in  1  physical memory done

Behaviour:
- Clock is clk. Reset is rst_n, synchronous, active-low: sampled only on the rising edge of clk.
- FSM states:
  - IDLE: no grant; pmem_read/pmem_write low.
  - GRANT_I: I-cache owns pmem.
  - GRANT_D: D-cache owns pmem.
- Client request: a client requests when its read or write is high. If both read and write are high, the request is treated as a write.
- IDLE transitions:
  - Only I requesting: GRANT_I.
  - Only D requesting: GRANT_D.
  - Both requesting, DCACHE_PRIORITY=1: GRANT_D.
  - Both requesting, DCACHE_PRIORITY=0: grant the client not recorded in last_grant.
  - On every grant, last_grant is updated to the granted client.
- Grant capture: on the IDLE->GRANT edge, register the granted client's op (read/write), address and wdata.
- Address alignment: pmem_address is the registered address with the low OFFSET_BITS forced to 0.
- pmem outputs: driven only from the registered values. pmem_read/pmem_write stay high through the whole GRANT state.
- GRANT_x -> IDLE: when pmem_resp=1. In that same cycle, x_mem_resp=1 combinationally; the other client's resp stays 0.
- rdata: i_mem_rdata and d_mem_rdata both pass pmem_rdata through. Only the resp qualifies which client consumes it.
- Latency:
  - Request first high in cycle N (arbiter in IDLE) -> pmem_* asserted from N+1.
  - pmem_resp in cycle M -> client resp in M, IDLE in M+1.
  - Next pmem command no earlier than M+2.
- Back-to-back same client: a D-cache writeback followed by an allocate read re-arbitrates in IDLE. Under round-robin, a waiting I-cache wins that slot.
- Request changes after grant: client request or address changes after grant do not affect the in-flight transaction. A request dropped mid-grant still completes the transaction.
- pmem_resp in IDLE: ignored; no client resp is generated.
- Reset values: FSM=IDLE, last_grant=D (so the first tie goes to I), pmem_read=0, pmem_write=0, i_mem_resp=0, d_mem_resp=0. pmem_address and pmem_wdata registers reset to 0.
- Reset mid-transaction: the in-flight access is abandoned. pmem_read/pmem_write are low in the cycle after the rst_n-low edge, and no resp is issued for it.

Decomposition:
- lc3b_types holds the following; lc3b_word is already in the package, the other two are added:
  - lc3b_word (16-bit)
  - lc3b_line (128-bit)
  - enum arb_state_t {ARB_IDLE, ARB_GRANT_I, ARB_GRANT_D}
- No sub-module: a single FSM plus capture registers.
- The tie-break function may be a local function.

Test Plan:
- I read 0x1234 alone -> pmem_read=1, pmem_address=0x1230 from the next cycle. pmem_resp with rdata=0xDEAD...BEEF -> i_mem_resp=1 that cycle with the line on i_mem_rdata; d_mem_resp stays 0.
- I and D request in the same cycle after reset (round-robin) -> I served first, then D. Repeat the simultaneous request -> I served first again, since last_grant=D after the D service.
- D write 0x4010 (wdata pattern A) then immediate D read 0x8020 while I reads 0x0100 -> order: D write, I read, D read. pmem_wdata=A during the write.
- DCACHE_PRIORITY=1, both clients request continuously -> only D is granted while d_mem_read is held. I is granted once D drops.
- rst_n low for one cycle during GRANT_D before pmem_resp -> pmem_read=0 the next cycle, no d_mem_resp; a late pmem_resp in IDLE yields no resp.
- pmem_resp held for 0 wait cycles (resp the cycle after assert) -> 2-cycle round trip. D request drops mid-grant -> transaction still completes with d_mem_resp=1.
